instr_fetch_queue: RTL and testbench

Decoupled instruction fetch stage that sits directly upstream of the single-cycle CPU core. It owns the fetch PC and issues sequential word reads to instruction memory over a req/ack handshake. Returned words are buffered, with their PCs, in a small FIFO that presents instructions to the core on a valid/ready interface. Branch and jump redirects from the core flush the queue and restart fetch at the target.

---
 rtl/ifq_pkg.sv | 19 +
 rtl/ifq_fifo.sv | 74 +++++++
 rtl/instr_fetch_queue.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Contents: the FSM state enum, PC step, word width and the FIFO entry struct.
package ifq_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } ifq_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Instruction/PC FIFO with synchronous flush. The head holds its last value when empty.
// Ports: clk, rst, flush, push, wr_entry, pop, head, empty, count_next.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  ifq_entry_t    wr_entry,
    input  logic          pop,
    output ifq_entry_t    head,
    output logic          empty,
    output logic [CW-1:0] count_next
);

    ifq_entry_t    mem [DEPTH];
    ifq_entry_t    hold_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push & ~flush & (~full | pop);
    assign pop_ok  = pop & ~flush & ~empty;

    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Keeps the head stable once the queue drains or is flushed.
    assign head = empty ? hold_q : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            count_q <= count_next;
            if (!empty) begin
                hold_q <= mem[rd_ptr_q];
            end
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupled fetch stage: owns the fetch PC, issues one-at-a-time imem reads, queues words for the core.
// Ports: clk_i/rst_i, redirect_i/redirect_pc_i, imem_req/addr/ack/data, instr_valid/instr/instr_pc/ready;
// with IFQ_PERF_COUNTERS_EN defined also perf_fetch_cnt_o and perf_flush_cnt_o.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        instr_pc_o,
    input  logic               instr_ready_i
`ifdef IFQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_flush_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drop_pc_q, drop_pc_d;
    logic          req_d;
    logic [31:0]   addr_d;
    logic          push;
    logic          pop;
    logic          empty;
    logic          inflight;
    logic          space;
    logic [CW-1:0] count_next;
    ifq_entry_t    wr_entry;
    ifq_entry_t    head;

    assign push = (state_q == REQ) & imem_req_o & imem_ack_i & ~redirect_i;
    assign pop  = ~empty & instr_ready_i & ~redirect_i;

    // A request still unacked after this cycle holds a reserved slot.
    assign inflight = imem_req_o & ~imem_ack_i;
    assign space    = ({1'b0, count_next} + (CW+1)'(inflight)) < (CW+1)'(DEPTH);

    assign wr_entry.pc    = imem_addr_o;
    assign wr_entry.instr = imem_data_i;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .flush      (redirect_i),
        .push       (push),
        .wr_entry   (wr_entry),
        .pop        (pop),
        .head       (head),
        .empty      (empty),
        .count_next (count_next)
    );

    assign instr_valid_o = ~empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_pc_d  = drop_pc_q;
        req_d      = imem_req_o;
        addr_d     = imem_addr_o;
        unique case (state_q)
            IDLE: begin
                // A redirect empties the queue, so the target can go out at once.
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    state_d    = REQ;
                    req_d      = 1'b1;
                    addr_d     = redirect_pc_i;
                end else if (space) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        state_d    = IDLE;
                        req_d      = 1'b0;
                        fetch_pc_d = redirect_pc_i;
                    end else begin
                        fetch_pc_d = imem_addr_o + PC_STEP;
                        if (space) begin
                            addr_d = imem_addr_o + PC_STEP;
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end else if (redirect_i) begin
                    state_d   = DROP;
                    drop_pc_d = redirect_pc_i;
                end
            end
            DROP: begin
                // Stale request must complete before fetching the target.
                if (imem_ack_i) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    fetch_pc_d = redirect_i ? redirect_pc_i
                                            : drop_pc_q;
                end else if (redirect_i) begin
                    drop_pc_d = redirect_pc_i;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_pc_q   <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_pc_q   <= drop_pc_d;
            imem_req_o  <= req_d;
            imem_addr_o <= addr_d;
        end
    end

`ifdef IFQ_PERF_COUNTERS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fetch_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (push)       perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            if (redirect_i) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue.
// Each task drives one scenario and checks outputs 1 time unit after the clock edge.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    // Memory model: word content is its address xor a fixed pattern.
    assign imem_data = imem_addr ^ PAT;

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready)
`ifdef IFQ_PERF_COUNTERS_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_flush_cnt_o (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        rst         = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_req got=%0h exp=0", imem_req);
        end
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr got=%0h exp=0", imem_addr);
        end
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%0h exp=0", instr_valid);
        end
        total++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_head got=%0h/%0h exp=0/0",
                     instr, instr_pc);
        end
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL first_req got=%0h@%0h exp=1@0",
                     imem_req, imem_addr);
        end
        // Reset asserted mid-cycle while a request is outstanding.
        rst = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_req got=%0h exp=0", imem_req);
        end
    endtask

    task automatic test_stream();
        do_reset();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0
            || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_c1 got=%0h@%0h v=%0h exp=1@0 v=0",
                     imem_req, imem_addr, instr_valid);
        end
        for (int k = 2; k <= 7; k++) begin
            step();
            total++;
            if (imem_addr !== 32'(4 * (k - 1))
                || instr_valid !== 1'b1
                || instr_pc !== 32'(4 * (k - 2))
                || instr !== (32'(4 * (k - 2)) ^ PAT)) begin
                bad++;
                $display("FAIL stream_c%0d got=a%0h v%0h pc%0h i%0h exp=a%0h v1 pc%0h",
                         k, imem_addr, instr_valid, instr_pc, instr,
                         4 * (k - 1), 4 * (k - 2));
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        imem_ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
                bad++;
                $display("FAIL fill_c%0d got=%0h@%0h exp=1@%0h",
                         k, imem_req, imem_addr, 4 * (k - 1));
            end
        end
        step();
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1
            || instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL full_stop got=r%0h v%0h pc%0h exp=r0 v1 pc0",
                     imem_req, instr_valid, instr_pc);
        end
        step();
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL full_hold got=%0h exp=0", imem_req);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10
            || instr_pc !== 32'h4) begin
            bad++;
            $display("FAIL refill got=%0h@%0h pc%0h exp=1@10 pc4",
                     imem_req, imem_addr, instr_pc);
        end
        step();
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL refill_single got=%0h exp=0", imem_req);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (instr_pc !== 32'(8 + 4 * k) || instr_valid !== 1'b1) begin
                bad++;
                $display("FAIL drain_%0d got=pc%0h v%0h exp=pc%0h v1",
                         k, instr_pc, instr_valid, 8 + 4 * k);
            end
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        instr_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0
                || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_c%0d got=%0h@%0h v%0h exp=1@0 v0",
                         k, imem_req, imem_addr, instr_valid);
            end
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0
            || instr !== PAT || imem_addr !== 32'h4) begin
            bad++;
            $display("FAIL ack_enq got=v%0h pc%0h i%0h a%0h exp=v1 pc0 i%0h a4",
                     instr_valid, instr_pc, instr, imem_addr, PAT);
        end
        step();
        total++;
        if (instr_valid !== 1'b0 || instr !== PAT
            || instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL empty_hold got=v%0h i%0h pc%0h exp=v0 i%0h pc0",
                     instr_valid, instr, instr_pc, PAT);
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        imem_ack = 1'b1;
        step();
        step();
        step();
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1
            || imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL drop_hold got=v%0h %0h@%0h exp=v0 1@8",
                     instr_valid, imem_req, imem_addr);
        end
        step();
        imem_ack = 1'b1;
        step();
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL drop_discard got=r%0h v%0h exp=r0 v0",
                     imem_req, instr_valid);
        end
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL drop_target got=%0h@%0h exp=1@100",
                     imem_req, imem_addr);
        end
        step();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100
            || instr !== 32'hA5A5_A4A5) begin
            bad++;
            $display("FAIL drop_first got=v%0h pc%0h i%0h exp=v1 pc100 iA5A5A4A5",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        imem_ack = 1'b1;
        step();
        step();
        step();
        total++;
        if (instr_valid !== 1'b1 || imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL two_queued got=v%0h a%0h exp=v1 a8",
                     instr_valid, imem_addr);
        end
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL redir_ack_flush got=v%0h r%0h exp=v0 r0",
                     instr_valid, imem_req);
        end
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            bad++;
            $display("FAIL redir_ack_target got=%0h@%0h exp=1@40",
                     imem_req, imem_addr);
        end
        step();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
            bad++;
            $display("FAIL redir_ack_first got=v%0h pc%0h exp=v1 pc40",
                     instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready = 1'b1;
        step();
        imem_ack    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL wrap_idle got=%0h exp=0", imem_req);
        end
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_req got=%0h@%0h exp=1@fffffffc",
                     imem_req, imem_addr);
        end
        step();
        total++;
        if (imem_addr !== 32'h0 || instr_valid !== 1'b1
            || instr_pc !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_next got=a%0h v%0h pc%0h exp=a0 v1 pcfffffffc",
                     imem_addr, instr_valid, instr_pc);
        end
    endtask

`ifdef IFQ_PERF_COUNTERS_EN
    task automatic test_perf();
        do_reset();
        total++;
        if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
            bad++;
            $display("FAIL perf_reset got=%0d/%0d exp=0/0",
                     perf_fetch_cnt, perf_flush_cnt);
        end
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 11; k++) step();
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        step();
        redirect = 1'b0;
        total++;
        if (perf_fetch_cnt !== 32'd10 || perf_flush_cnt !== 32'd2) begin
            bad++;
            $display("FAIL perf_counts got=%0d/%0d exp=10/2",
                     perf_fetch_cnt, perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_ack_delay();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
`ifdef IFQ_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
